// File: rtl/axi_stream_remove_header.sv
// rtl/axi_stream_remove_header.sv - strips a per-packet byte count from the head of an AXI-Stream packet and realigns the payload
module axi_stream_remove_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int DATA_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    input  logic                    valid_strip,
    input  logic [DATA_CNT_WD:0]    strip_len,
    output logic                    ready_strip,
    output logic                    short_pkt
);
    localparam int CW = DATA_CNT_WD + 1;
    localparam logic [CW-1:0] B_CNT  = CW'(DATA_BYTE_WD);
    localparam logic [CW:0]   B_WIDE = (CW + 1)'(DATA_BYTE_WD);

    typedef enum logic [1:0] {IDLE, FIRST, MERGE, FLUSH} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           s_q, s_d;
    logic [CW-1:0]           r_q, r_d;
    logic [DATA_WD-1:0]      res_q, res_d;
    logic                    valid_out_q, valid_out_d;
    logic [DATA_WD-1:0]      data_out_q, data_out_d;
    logic [DATA_BYTE_WD-1:0] keep_out_q, keep_out_d;
    logic                    last_out_q, last_out_d;
    logic                    short_pkt_q, short_pkt_d;

    logic [DATA_WD-1:0]      din_m;
    logic [CW-1:0]           n_in;
    logic [CW:0]             sum;
    logic                    out_free;

    function automatic logic [DATA_BYTE_WD-1:0] msb_mask(input logic [CW:0] c);
        logic [DATA_BYTE_WD-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            m[DATA_BYTE_WD-1-i] = (i < int'(c));
        end
        return m;
    endfunction

    // Invalid lanes are zeroed up front so they can never leak into data_out.
    always_comb begin
        din_m = '0;
        n_in  = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            din_m[8*i +: 8] = data_in[8*i +: 8] & {8{keep_in[i]}};
            n_in            = n_in + CW'(keep_in[i]);
        end
    end

    assign sum         = {1'b0, r_q} + {1'b0, n_in};
    assign out_free    = !valid_out_q || ready_out;
    assign ready_strip = (state_q == IDLE) && !rst;

    always_comb begin
        ready_in = 1'b0;
        case (state_q)
            FIRST:   ready_in = 1'b1;
            MERGE:   ready_in = out_free;
            default: ready_in = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        r_d         = r_q;
        res_d       = res_q;
        valid_out_d = valid_out_q && !ready_out;
        data_out_d  = data_out_q;
        keep_out_d  = keep_out_q;
        last_out_d  = last_out_q;
        short_pkt_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_strip) begin
                    s_d     = (strip_len > B_WIDE) ? B_CNT : strip_len[CW-1:0];
                    state_d = FIRST;
                end
            end
            FIRST: begin
                if (valid_in) begin
                    if (last_in && n_in <= s_q) begin
                        short_pkt_d = 1'b1;
                        r_d         = '0;
                        res_d       = '0;
                        state_d     = IDLE;
                    end else begin
                        r_d     = n_in - s_q;
                        res_d   = din_m << {s_q, 3'b000};
                        state_d = last_in ? FLUSH : MERGE;
                    end
                end
            end
            MERGE: begin
                if (valid_in && out_free) begin
                    valid_out_d = 1'b1;
                    data_out_d  = res_q | (din_m >> {r_q, 3'b000});
                    if (last_in && sum <= B_WIDE) begin
                        keep_out_d = msb_mask(sum);
                        last_out_d = 1'b1;
                        r_d        = '0;
                        res_d      = '0;
                        state_d    = IDLE;
                    end else begin
                        keep_out_d = '1;
                        last_out_d = 1'b0;
                        r_d        = CW'(sum - B_WIDE);
                        res_d      = din_m << {B_CNT - r_q, 3'b000};
                        state_d    = last_in ? FLUSH : MERGE;
                    end
                end
            end
            FLUSH: begin
                if (out_free) begin
                    valid_out_d = 1'b1;
                    data_out_d  = res_q;
                    keep_out_d  = msb_mask({1'b0, r_q});
                    last_out_d  = 1'b1;
                    r_d         = '0;
                    res_d       = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            s_q         <= '0;
            r_q         <= '0;
            res_q       <= '0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            keep_out_q  <= '0;
            last_out_q  <= 1'b0;
            short_pkt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            r_q         <= r_d;
            res_q       <= res_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            keep_out_q  <= keep_out_d;
            last_out_q  <= last_out_d;
            short_pkt_q <= short_pkt_d;
        end
    end

    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;
    assign keep_out  = keep_out_q;
    assign last_out  = last_out_q;
    assign short_pkt = short_pkt_q;
endmodule

// File: tb/tb_axi_stream_remove_header.sv
// tb/tb_axi_stream_remove_header.sv - directed scoreboard bench for axi_stream_remove_header
module tb_axi_stream_remove_header;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [31:0] data_in;
    logic [3:0]  keep_in;
    logic        last_in;
    logic        ready_in;
    logic        valid_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        last_out;
    logic        ready_out;
    logic        valid_strip;
    logic [2:0]  strip_len;
    logic        ready_strip;
    logic        short_pkt;

    int n_checks = 0;
    int n_pass   = 0;
    logic [36:0] exp_q[$];
    logic [36:0] snap;

    always #5 clk = ~clk;

    axi_stream_remove_header #(.DATA_WD(32)) dut (
        .clk(clk), .rst(rst),
        .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
        .ready_in(ready_in),
        .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
        .ready_out(ready_out),
        .valid_strip(valid_strip), .strip_len(strip_len), .ready_strip(ready_strip),
        .short_pkt(short_pkt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    always @(negedge clk) begin
        if (!rst && valid_out && ready_out) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {data_out, keep_out, last_out}, 64'd0);
            end else begin
                chk("out_beat", {data_out, keep_out, last_out}, exp_q.pop_front());
            end
        end
    end

    task automatic push(input logic [31:0] d, input logic [3:0] k, input logic l);
        exp_q.push_back({d, k, l});
    endtask

    task automatic send_strip(input logic [2:0] s);
        int cnt;
        valid_strip = 1'b1;
        strip_len   = s;
        cnt = 0;
        @(negedge clk);
        while (!ready_strip && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("strip_accept", ready_strip, 1);
        @(posedge clk);
        #1;
        valid_strip = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int cnt;
        valid_in = 1'b1;
        data_in  = d;
        keep_in  = k;
        last_in  = l;
        cnt = 0;
        @(negedge clk);
        while (!ready_in && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("beat_accept", ready_in, 1);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic drain();
        int cnt;
        cnt = 0;
        while ((exp_q.size() != 0 || valid_out) && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
        ready_out = 1'b1; valid_strip = 1'b0; strip_len = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_out", valid_out, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_keep_out", keep_out, 0);
        chk("rst_last_out", last_out, 0);
        chk("rst_short_pkt", short_pkt, 0);
        chk("rst_ready_strip", ready_strip, 0);
        chk("rst_ready_in", ready_in, 0);
        rst = 1'b0;
        #1;
        chk("idle_ready_strip", ready_strip, 1);

        // S=1, three beats with a spilled tail
        push(32'h11223344, 4'hF, 1'b0);
        push(32'h55667788, 4'hF, 1'b0);
        push(32'h99AABB00, 4'hE, 1'b1);
        send_strip(3'd1);
        send_beat(32'h00112233, 4'hF, 1'b0);
        send_beat(32'h44556677, 4'hF, 1'b0);
        send_beat(32'h8899AABB, 4'hF, 1'b1);
        drain();

        // S=2, tail fits: one beat out, back to IDLE with no FLUSH
        push(32'hA2A3B0B1, 4'hF, 1'b1);
        send_strip(3'd2);
        send_beat(32'hA0A1A2A3, 4'hF, 1'b0);
        send_beat(32'hB0B1B2B3, 4'hC, 1'b1);
        chk("s2_valid_next", valid_out, 1);
        chk("s2_ready_strip", ready_strip, 1);
        drain();

        // Short packets are dropped
        send_strip(3'd4);
        send_beat(32'hDEADBEEF, 4'hF, 1'b1);
        chk("drop4_short", short_pkt, 1);
        chk("drop4_ready_strip", ready_strip, 1);
        chk("drop4_valid_out", valid_out, 0);
        @(posedge clk); #1;
        chk("drop4_short_clr", short_pkt, 0);
        send_strip(3'd3);
        send_beat(32'hDEADBE00, 4'hE, 1'b1);
        chk("drop3_short", short_pkt, 1);
        chk("drop3_ready_strip", ready_strip, 1);
        @(posedge clk); #1;
        chk("drop3_short_clr", short_pkt, 0);
        send_strip(3'd7);
        send_beat(32'hDEADBEEF, 4'hF, 1'b1);
        chk("drop7_short", short_pkt, 1);
        chk("drop7_valid_out", valid_out, 0);
        @(posedge clk); #1;

        // S=0 pass-through with a FLUSH beat
        push(32'h01020304, 4'hF, 1'b0);
        push(32'h05000000, 4'h8, 1'b1);
        send_strip(3'd0);
        send_beat(32'h01020304, 4'hF, 1'b0);
        send_beat(32'h05060708, 4'h8, 1'b1);
        drain();

        // Backpressure: stall 3 cycles after the first output beat
        push(32'h11223344, 4'hF, 1'b0);
        push(32'h55667788, 4'hF, 1'b0);
        push(32'h99AABB00, 4'hE, 1'b1);
        send_strip(3'd1);
        send_beat(32'h00112233, 4'hF, 1'b0);
        send_beat(32'h44556677, 4'hF, 1'b0);
        ready_out = 1'b0;
        chk("stall_first_valid", valid_out, 1);
        snap = {data_out, keep_out, last_out};
        valid_in = 1'b1; data_in = 32'h8899AABB; keep_in = 4'hF; last_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_hold", {data_out, keep_out, last_out}, snap);
            chk("stall_ready_in", ready_in, 0);
            @(posedge clk); #1;
        end
        ready_out = 1'b1;
        send_beat(32'h8899AABB, 4'hF, 1'b1);
        drain();

        // Reset mid-packet, then a fresh packet
        send_strip(3'd1);
        send_beat(32'hCAFEF00D, 4'hF, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_valid_out", valid_out, 0);
        chk("midrst_ready_strip", ready_strip, 0);
        rst = 1'b0;
        #1;
        chk("midrst_ready_strip_after", ready_strip, 1);
        push(32'h11223344, 4'hF, 1'b0);
        push(32'h55667788, 4'hF, 1'b0);
        push(32'h99AABB00, 4'hE, 1'b1);
        send_strip(3'd1);
        send_beat(32'h00112233, 4'hF, 1'b0);
        send_beat(32'h44556677, 4'hF, 1'b0);
        send_beat(32'h8899AABB, 4'hF, 1'b1);
        drain();

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
